// File: rtl/game_mode_ctrl.sv
// Game-flow controller for the tank game: IDLE/CLASSIC/INFINITY/PAUSE/OVER sequencing
// with registered subsystem enables decoded from the next state.
module game_mode_ctrl #(
    parameter int N_ENEMY         = 4,
    parameter int CLASSIC_ENEMIES = 4,
    parameter int PROTECT_CYCLES  = 300000000,
    parameter int OVER_HOLD       = 100000000,
    parameter int CNT_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bt_st,
    input  logic               btn_mode_sel,
    input  logic               btn_pause,
    input  logic               btn_return,
    input  logic               gameover_classic,
    input  logic               gameover_infinity,
    output logic [N_ENEMY-1:0] enable_enemy_control,
    output logic [N_ENEMY-1:0] enable_enemy_display,
    output logic [N_ENEMY-1:0] enable_enemy_shell,
    output logic               enable_myshell,
    output logic               enable_mytank_control,
    output logic               enable_mytank_display,
    output logic               enable_game_classic,
    output logic               enable_game_infinity,
    output logic               enable_reward,
    output logic               enable_startmusic,
    output logic               enable_gamemusic,
    output logic               start_protect,
    output logic [2:0]         mode
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLASSIC  = 3'd1,
        S_INFINITY = 3'd2,
        S_OVER     = 3'd3,
        S_PAUSE    = 3'd4
    } state_t;

    function automatic logic [N_ENEMY-1:0] classic_mask();
        logic [N_ENEMY-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < unsigned'(N_ENEMY); i++)
            m[i] = (i < unsigned'(CLASSIC_ENEMIES));
        return m;
    endfunction

    localparam logic [N_ENEMY-1:0] CLASSIC_MASK = classic_mask();
    localparam logic [CNT_W-1:0]   PROT_LAST    = CNT_W'(PROTECT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_MAX     = CNT_W'(OVER_HOLD);

    state_t             state, nxt;
    logic               saved_classic, saved_nx;
    logic               st_d, pause_d, ret_d;
    logic               st_e, pause_e, ret_e;
    logic [CNT_W-1:0]   prot_cnt, hold_cnt;
    logic               in_game;

    logic [N_ENEMY-1:0] ctrl_nx, disp_nx, shell_nx;
    logic               myshell_nx, mytank_ctrl_nx, mytank_disp_nx;
    logic               classic_nx, infinity_nx, reward_nx, startmusic_nx, gamemusic_nx;

    assign st_e    = bt_st & ~st_d;
    assign pause_e = btn_pause & ~pause_d;
    assign ret_e   = btn_return & ~ret_d;
    assign in_game = (state == S_CLASSIC) || (state == S_INFINITY);
    assign mode    = state;

    always_comb begin
        nxt      = state;
        saved_nx = saved_classic;
        case (state)
            S_IDLE:     if (st_e) nxt = btn_mode_sel ? S_CLASSIC : S_INFINITY;
            S_CLASSIC: begin
                if (gameover_classic) nxt = S_OVER;
                else if (pause_e) begin
                    nxt      = S_PAUSE;
                    saved_nx = 1'b1;
                end
            end
            S_INFINITY: begin
                if (gameover_infinity) nxt = S_OVER;
                else if (pause_e) begin
                    nxt      = S_PAUSE;
                    saved_nx = 1'b0;
                end
            end
            S_PAUSE: begin
                if (ret_e)        nxt = S_IDLE;
                else if (pause_e) nxt = saved_classic ? S_CLASSIC : S_INFINITY;
            end
            S_OVER:     if (ret_e && hold_cnt == HOLD_MAX) nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
    end

    // Enables are decoded from the upcoming state so they land on the same edge as mode.
    always_comb begin
        ctrl_nx        = '0;
        disp_nx        = '0;
        shell_nx       = '0;
        myshell_nx     = 1'b0;
        mytank_ctrl_nx = 1'b0;
        mytank_disp_nx = 1'b0;
        classic_nx     = 1'b0;
        infinity_nx    = 1'b0;
        reward_nx      = 1'b0;
        startmusic_nx  = 1'b0;
        gamemusic_nx   = 1'b0;
        case (nxt)
            S_IDLE: startmusic_nx = 1'b1;
            S_CLASSIC, S_INFINITY: begin
                ctrl_nx        = (nxt == S_CLASSIC) ? CLASSIC_MASK : '1;
                disp_nx        = ctrl_nx;
                shell_nx       = ctrl_nx;
                myshell_nx     = 1'b1;
                mytank_ctrl_nx = 1'b1;
                mytank_disp_nx = 1'b1;
                reward_nx      = 1'b1;
                classic_nx     = (nxt == S_CLASSIC);
                infinity_nx    = (nxt == S_INFINITY);
            end
            S_PAUSE: begin
                disp_nx        = saved_nx ? CLASSIC_MASK : '1;
                mytank_disp_nx = 1'b1;
                classic_nx     = saved_nx;
                infinity_nx    = ~saved_nx;
            end
            S_OVER: gamemusic_nx = 1'b1;
            default: startmusic_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_IDLE;
            saved_classic         <= 1'b1;
            st_d                  <= 1'b1;
            pause_d               <= 1'b1;
            ret_d                 <= 1'b1;
            prot_cnt              <= '0;
            hold_cnt              <= '0;
            start_protect         <= 1'b0;
            enable_enemy_control  <= '0;
            enable_enemy_display  <= '0;
            enable_enemy_shell    <= '0;
            enable_myshell        <= 1'b0;
            enable_mytank_control <= 1'b0;
            enable_mytank_display <= 1'b0;
            enable_game_classic   <= 1'b0;
            enable_game_infinity  <= 1'b0;
            enable_reward         <= 1'b0;
            enable_startmusic     <= 1'b1;
            enable_gamemusic      <= 1'b0;
        end else begin
            state                 <= nxt;
            saved_classic         <= saved_nx;
            st_d                  <= bt_st;
            pause_d               <= btn_pause;
            ret_d                 <= btn_return;
            enable_enemy_control  <= ctrl_nx;
            enable_enemy_display  <= disp_nx;
            enable_enemy_shell    <= shell_nx;
            enable_myshell        <= myshell_nx;
            enable_mytank_control <= mytank_ctrl_nx;
            enable_mytank_display <= mytank_disp_nx;
            enable_game_classic   <= classic_nx;
            enable_game_infinity  <= infinity_nx;
            enable_reward         <= reward_nx;
            enable_startmusic     <= startmusic_nx;
            enable_gamemusic      <= gamemusic_nx;

            // A game cycle that ends by pausing still counts toward protection.
            if (state == S_IDLE && nxt != S_IDLE) begin
                prot_cnt      <= '0;
                start_protect <= 1'b1;
            end else if (nxt == S_OVER || nxt == S_IDLE) begin
                start_protect <= 1'b0;
            end else if (in_game && start_protect) begin
                prot_cnt <= prot_cnt + CNT_W'(1);
                if (prot_cnt == PROT_LAST) start_protect <= 1'b0;
            end

            if (nxt == S_OVER && state != S_OVER)
                hold_cnt <= '0;
            else if (state == S_OVER && hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

endmodule
